// File: rtl/mc_control_fsm_pkg.sv
// rtl/mc_control_fsm_pkg.sv - state codes, opcodes, ALU codes and mux selects for the multicycle sequencer
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_control_fsm_alu_ctrl.sv
// rtl/mc_control_fsm_alu_ctrl.sv - combinational ALU operation decode from state and instruction fields
module mc_alu_ctrl
  import mc_control_fsm_pkg::*;
(
  input  state_e     state_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (state_i)
      ST_BRANCH: alu_control_o = ALU_SUB;
      ST_EXECR, ST_EXECI: begin
        // op[5] separates R-type from I-type: addi never subtracts even with IR[30] set
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle RISC-V control sequencer over a shared ready-handshaked memory
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int ST_W       = 4
) (
  input  logic                  clk,
  input  logic                  Async_reset,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  input  logic                  neg,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            imm_src,
  output logic                  illegal,
  output logic [ST_W-1:0]       state
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [2:0] alu_ctrl;
  logic       taken;

  mc_alu_ctrl u_alu_ctrl (
    .state_i       (state_q),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .op5_i         (op[5]),
    .alu_control_o (alu_ctrl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_R:         state_d = ST_EXECR;
          OP_I:         state_d = ST_EXECI;
          OP_BR:        state_d = ST_BRANCH;
          OP_JAL:       state_d = ST_JAL;
          default:      state_d = ST_TRAP;
        endcase
      end
      ST_MEMADR:   state_d = op[5] ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWB:    state_d = ST_FETCH;
      ST_MEMWRITE: if (mem_ready) state_d = ST_FETCH;
      ST_EXECR:    state_d = ST_ALUWB;
      ST_EXECI:    state_d = ST_ALUWB;
      ST_ALUWB:    state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JAL:      state_d = ST_ALUWB;
      ST_TRAP:     state_d = ST_TRAP;
      default:     state_d = ST_FETCH;
    endcase
    illegal_d = illegal_q | (state_d == ST_TRAP);
  end

  always_ff @(posedge clk or negedge Async_reset) begin
    if (!Async_reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = neg;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_control = ALU_CTRL_W'(alu_ctrl);
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BR:   imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
    case (state_q)
      ST_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      ST_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      ST_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      ST_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
      end
      ST_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      ST_EXECR:  alu_src_a = SRCA_RS1;
      ST_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      ST_ALUWB:  reg_write = 1'b1;
      ST_BRANCH: begin
        alu_src_a = SRCA_RS1;
        pc_write  = taken;
      end
      ST_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    // Reset must silence every output immediately, not just at the next edge
    if (!Async_reset) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = '0;
      imm_src     = 2'b00;
    end
  end

  assign illegal = illegal_q;
  assign state   = ST_W'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - randomized instruction-level check of the multicycle sequencer
module tb_mc_control_fsm;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  logic       clk = 1'b0;
  logic       Async_reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, neg, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  int zmode = -1;
  bit exp_illegal = 1'b0;

  mc_control_fsm dut (
    .clk(clk), .Async_reset(Async_reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .neg(neg), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  wire [31:0] obs = {10'd0, state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                     result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal};

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [2:0] alu_op(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    if (f3 == 3'b000 && o == RT && f7) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BR) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // One clock of a given instruction phase: drive, sample mid-cycle, advance to the next edge
  task automatic cycle(input int ph, input bit rdy);
    bit mreq, mw, adr, irw, pcw, rw, tk;
    logic [1:0] rs, a, b;
    logic [2:0] alu;
    {mreq, mw, adr, irw, pcw, rw} = '0;
    rs = 2'b00; a = 2'b00; b = 2'b00; alu = 3'b000;
    mem_ready = rdy;
    zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    neg  = 1'($urandom_range(0, 1));
    tk = (funct3 == 3'd0) ? zero : (funct3 == 3'd1) ? !zero : (funct3 == 3'd4) ? neg : 1'b0;
    case (ph)
      0:  begin mreq = 1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  begin mreq = 1; adr = 1; end
      4:  begin rs = 2'b01; rw = 1; end
      5:  begin mreq = 1; mw = 1; adr = 1; end
      6:  begin a = 2'b10; alu = alu_op(op, funct3, funct7b5); end
      7:  begin a = 2'b10; b = 2'b01; alu = alu_op(op, funct3, funct7b5); end
      8:  rw = 1;
      9:  begin a = 2'b10; alu = 3'b001; pcw = tk; end
      10: begin a = 2'b01; b = 2'b10; pcw = 1; end
      11: exp_illegal = 1'b1;
      default: ;
    endcase
    #4;
    check($sformatf("phase%0d_op%b_f3%b", ph, op, funct3), obs,
          {10'd0, 4'(ph), mreq, mw, adr, irw, pcw, rw, rs, a, b, alu, imm_of(op), exp_illegal});
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int stall);
    int phs[$];
    op = o; funct3 = f3; funct7b5 = f7;
    case (o)
      LW:      phs = '{0, 1, 2, 3, 4};
      SW:      phs = '{0, 1, 2, 5};
      RT:      phs = '{0, 1, 6, 8};
      IT:      phs = '{0, 1, 7, 8};
      BR:      phs = '{0, 1, 9};
      JL:      phs = '{0, 1, 10, 8};
      default: phs = '{0, 1, 11};
    endcase
    foreach (phs[i]) begin
      if (phs[i] == 0 || phs[i] == 3 || phs[i] == 5) begin
        int n = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        repeat (n) cycle(phs[i], 1'b0);
        cycle(phs[i], 1'b1);
      end else begin
        cycle(phs[i], 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [6];
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = BR; ops[5] = JL;
    Async_reset = 1'b0; op = LW; funct3 = 3'd0; funct7b5 = 1'b0;
    zero = 1'b0; neg = 1'b0; mem_ready = 1'b0;
    #3;
    check("reset_outputs", obs, 32'd0);
    @(posedge clk);
    #1;
    Async_reset = 1'b1;

    run_instr(LW, 3'b010, 1'b0, 0);
    run_instr(RT, 3'b000, 1'b0, 0);
    run_instr(RT, 3'b000, 1'b1, 0);
    zmode = 1;
    run_instr(BR, 3'b000, 1'b0, 0);
    run_instr(BR, 3'b001, 1'b0, 0);
    zmode = -1;
    run_instr(IT, 3'b000, 1'b1, 3);
    run_instr(SW, 3'b010, 1'b0, 0);
    run_instr(JL, 3'b000, 1'b0, 0);

    for (int k = 0; k < 80; k++)
      run_instr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1);

    op = SW; funct3 = 3'b010; funct7b5 = 1'b0;
    cycle(0, 1'b1);
    cycle(1, 1'b0);
    cycle(2, 1'b0);
    mem_ready = 1'b0;
    #2;
    check("memwrite_before_reset", {31'd0, mem_write}, 32'd1);
    Async_reset = 1'b0;
    #1;
    check("reset_mid_memwrite", obs, 32'd0);
    @(posedge clk);
    #1;
    Async_reset = 1'b1;
    run_instr(SW, 3'b010, 1'b0, 1);

    run_instr(7'b1111111, 3'b000, 1'b0, 0);
    repeat (10) cycle(11, 1'($urandom_range(0, 1)));
    #2;
    Async_reset = 1'b0;
    exp_illegal = 1'b0;
    #1;
    check("reset_clears_trap", obs, 32'd0);
    @(posedge clk);
    #1;
    Async_reset = 1'b1;
    run_instr(IT, 3'b111, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
